// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and timing constants for the SDRAM port arbiter
//
// Purpose: access-sequencer state type and the two fixed wait lengths used by
//          sdram_port_arb. No ports.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE,
    ST_RECOVER
  } arb_state_t;

  // Cycles to wait for ram_busy before assuming the controller served a cache hit.
  localparam int HIT_WAIT = 2;
  // Cycles both strobes are held low after an access so the next one is a fresh edge.
  localparam int RECOVER_LEN = 1;
  // Width of the shared per-state cycle counter; must hold HIT_WAIT-1 and RECOVER_LEN-1.
  localparam int CNT_W = 2;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational winner selection for the SDRAM port arbiter
//
// Purpose: picks exactly one requester from the valid vector.
//   SDRAM_ARB_RR_EN defined  : round-robin, search starts at ptr.
//   SDRAM_ARB_RR_EN undefined: fixed priority, lowest index wins, ptr ignored.
// Ports:
//   valid [NREQ]  : request vector
//   ptr   [IDX_W] : round-robin start index
//   grant [NREQ]  : one-hot winner (all zero when no request)
//   idx   [IDX_W] : winner index (0 when no request)
module sdram_arb_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

`ifdef SDRAM_ARB_RR_EN
  // Scan from the farthest candidate down to ptr itself so the last hit,
  // i.e. the one closest to ptr, is the one that sticks.
  always_comb begin : rr_pick
    int               pos;
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    pos   = 0;
    j     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      j = IDX_W'(pos);
      if (valid[j]) begin
        grant = NREQ'(1) << j;
        idx   = j;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin : fixed_pick
    grant = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        grant = NREQ'(1) << i;
        idx   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/sdram_port_arb.sv
// rtl/sdram_port_arb.sv - multi-requester front end for a single-byte SDRAM controller port
//
// Purpose: grants one requester at a time, issues an edge-sensed read or write
//          strobe to the controller, waits for completion (busy pulse or cache
//          hit), returns a one-cycle ack and the read byte.
// Config : SDRAM_ARB_RR_EN selects round-robin arbitration; default is fixed
//          priority with index 0 highest.
// Ports:
//   clk, init_n          : clock, synchronous active-low reset
//   req_valid/we/addr/din: per-requester level request and its payload
//   req_ack              : one-cycle completion pulse per requester
//   req_dout             : last read byte, valid from the ack cycle onwards
//   ram_addr/din/we/rd   : controller command port (strobes are edge-sensed)
//   ram_dout, ram_busy   : controller read data and busy flag
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 25
) (
  input  logic                        clk,
  input  logic                        init_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0][7:0]        req_din,
  output logic [NREQ-1:0]             req_ack,
  output logic [7:0]                  req_dout,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [7:0]                  ram_din,
  output logic                        ram_we,
  output logic                        ram_rd,
  input  logic [7:0]                  ram_dout,
  input  logic                        ram_busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] win_idx;
  logic             lat_we;
  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] ptr;
  logic             grant_now;

  sdram_arb_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign grant_now = (state == ST_IDLE) && (state_nxt == ST_ISSUE);

  // State register; cnt restarts on every state change and times the current state.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (|pick_grant && !ram_busy) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (ram_busy)                             state_nxt = ST_WAIT_DONE;
        else if (cnt == CNT_W'(HIT_WAIT - 1))     state_nxt = ST_DONE;
      end
      ST_WAIT_DONE: if (!ram_busy) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_RECOVER;
      ST_RECOVER:   if (cnt == CNT_W'(RECOVER_LEN - 1)) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_rd  = 1'b0;
    ram_we  = 1'b0;
    req_ack = '0;
    if (state inside {ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_DONE}) begin
      ram_we = lat_we;
      ram_rd = !lat_we;
    end
    if (state == ST_DONE) req_ack[win_idx] = 1'b1;
  end

  // Access payload is latched only at grant, so it cannot move mid-access
  // even if the requester changes or drops its inputs.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      win_idx  <= '0;
      lat_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      req_dout <= '0;
    end else begin
      if (grant_now) begin
        win_idx  <= pick_idx;
        lat_we   <= req_we[pick_idx];
        ram_addr <= req_addr[pick_idx];
        ram_din  <= req_din[pick_idx];
      end
      // Capture on entry to DONE so the byte is already valid in the ack cycle.
      if (state != ST_DONE && state_nxt == ST_DONE && !lat_we) req_dout <= ram_dout;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!init_n)        ptr <= '0;
    else if (grant_now) ptr <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  end
`else
  assign ptr = '0;
`endif

endmodule
